term_serializer: RTL and testbench

TERM_SERIALIZER -- requirements
Module: term_serializer

---
 rtl/term_serializer.sv | 129 ++++++++++++
 tb/tb_term_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/term_serializer.sv
// Term serializer: captures a vector of signed terms and streams them out one per enabled cycle,
// preceded by a single clear pulse. Optional macro TERM_SERIALIZER_SKIP_ZERO_EN skips zero terms.
module term_serializer #(
   parameter int IN_WIDTH  = 16,
   parameter int NUM_TERMS = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic                          load_valid_i,
   output logic                          load_ready_o,
   input  logic [NUM_TERMS*IN_WIDTH-1:0] terms_i,
   output logic                          clear_o,
   output logic                          valid_o,
   output logic signed [IN_WIDTH-1:0]    data_o,
   output logic                          last_o,
   output logic                          busy_o
);

   localparam int IDX_W = $clog2(NUM_TERMS);
   typedef logic [IDX_W-1:0] idx_t;
   localparam idx_t LAST_IDX = idx_t'(NUM_TERMS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      STREAM
   } state_t;

   state_t                      state_q, state_d;
   idx_t                        idx_q, idx_d;
   logic signed [IN_WIDTH-1:0]  shadow_q [NUM_TERMS];
   logic signed [IN_WIDTH-1:0]  shadow_d [NUM_TERMS];
   logic                        final_term;
   idx_t                        first_idx;
   idx_t                        next_idx;

`ifdef TERM_SERIALIZER_SKIP_ZERO_EN
   logic found_first;
   logic found_next;

   // An all-zero vector falls back to index 0 with no successor, so it emits one zero term marked last.
   always_comb begin
      found_first = 1'b0;
      found_next  = 1'b0;
      first_idx   = '0;
      next_idx    = idx_q;
      for (int k = 0; k < NUM_TERMS; k++) begin
         if (shadow_q[k] != '0) begin
            if (!found_first) begin
               first_idx   = idx_t'(k);
               found_first = 1'b1;
            end
            if (!found_next && (idx_t'(k) > idx_q)) begin
               next_idx   = idx_t'(k);
               found_next = 1'b1;
            end
         end
      end
      final_term = !found_next;
   end
`else
   always_comb begin
      first_idx  = '0;
      next_idx   = idx_q + idx_t'(1);
      final_term = (idx_q == LAST_IDX);
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         for (int k = 0; k < NUM_TERMS; k++) begin
            shadow_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      if (en_i) begin
         case (state_q)
            IDLE: begin
               if (load_valid_i) begin
                  for (int k = 0; k < NUM_TERMS; k++) begin
                     shadow_d[k] = terms_i[k*IN_WIDTH +: IN_WIDTH];
                  end
                  idx_d   = '0;
                  state_d = CLEAR;
               end
            end
            CLEAR: begin
               idx_d   = first_idx;
               state_d = STREAM;
            end
            STREAM: begin
               if (final_term) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = next_idx;
               end
            end
            default: begin
               idx_d   = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // Moore outputs: only registered state reaches data_o; en_i gates the strobes.
   always_comb begin
      load_ready_o = en_i && (state_q == IDLE);
      clear_o      = en_i && (state_q == CLEAR);
      valid_o      = en_i && (state_q == STREAM);
      last_o       = valid_o && final_term;
      data_o       = valid_o ? shadow_q[idx_q] : '0;
      busy_o       = (state_q != IDLE);
   end

endmodule

// File: tb/tb_term_serializer.sv
// Directed testbench for term_serializer (NUM_TERMS=4, IN_WIDTH=16): table-driven vectors plus
// hand-written sequences for back-pressure, enable stalls and asynchronous reset.
module tb_term_serializer;

   localparam int NT = 4;
   localparam int W  = 16;

   typedef struct {
      logic [NT*W-1:0] terms;
      int              n;
      logic [W-1:0]    exp [NT];
   } vec_t;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                en_i;
   logic                load_valid_i;
   logic                load_ready_o;
   logic [NT*W-1:0]     terms_i;
   logic                clear_o;
   logic                valid_o;
   logic signed [W-1:0] data_o;
   logic                last_o;
   logic                busy_o;

   int total = 0;
   int bad   = 0;
   int accept_cnt = 0;
   logic signed [19:0] acc = '0;
   logic               acc_ovf = 1'b0;
   vec_t               tbl [5];

   term_serializer #(.IN_WIDTH(W), .NUM_TERMS(NT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .load_valid_i(load_valid_i),
      .load_ready_o(load_ready_o), .terms_i(terms_i), .clear_o(clear_o), .valid_o(valid_o),
      .data_o(data_o), .last_o(last_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Downstream accumulator model and acceptance counter, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (load_valid_i && load_ready_o) accept_cnt++;
      if (clear_o) begin
         acc     <= '0;
         acc_ovf <= 1'b0;
      end else if (valid_o) begin
         acc <= acc + 20'(data_o);
         if ((acc + 20'(data_o)) > 20'sd131071 || (acc + 20'(data_o)) < -20'sd131072) acc_ovf <= 1'b1;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog act=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Starts in the clear cycle just after acceptance; ends in the following IDLE cycle.
   task automatic expect_stream(input string tag, input logic [W-1:0] e [NT], input int n);
      check({tag, " clear"}, 32'(clear_o), 32'd1);
      check({tag, " clear valid"}, 32'(valid_o), 32'd0);
      check({tag, " clear busy"}, 32'(busy_o), 32'd1);
      check({tag, " clear ready"}, 32'(load_ready_o), 32'd0);
      for (int i = 0; i < n; i++) begin
         cyc();
         check($sformatf("%s term%0d valid", tag, i), 32'(valid_o), 32'd1);
         check($sformatf("%s term%0d data", tag, i), 32'($unsigned(data_o)), 32'(e[i]));
         check($sformatf("%s term%0d last", tag, i), 32'(last_o), (i == n - 1) ? 32'd1 : 32'd0);
         check($sformatf("%s term%0d clear", tag, i), 32'(clear_o), 32'd0);
      end
      cyc();
      check({tag, " end ready"}, 32'(load_ready_o), 32'd1);
      check({tag, " end busy"}, 32'(busy_o), 32'd0);
      check({tag, " end valid"}, 32'(valid_o), 32'd0);
      check({tag, " end data"}, 32'($unsigned(data_o)), 32'd0);
   endtask

   task automatic apply_stimulus(input logic [NT*W-1:0] v);
      terms_i      = v;
      load_valid_i = 1'b1;
      #1;
      check("offer ready", 32'(load_ready_o), 32'd1);
      cyc();
      load_valid_i = 1'b0;
      terms_i      = {$urandom, $urandom};
      #1;
   endtask

   initial begin
      logic [W-1:0] e3 [NT];
      logic [W-1:0] e9 [NT];
      logic [W-1:0] e1234 [NT];
      logic [W-1:0] e10 [NT];

      tbl[0].terms = {16'hFFFB, 16'h0007, 16'hFFFF, 16'h0003};
      tbl[1].terms = {16'hFFFE, 16'h0000, 16'h0005, 16'h0000};
      tbl[2].terms = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
      tbl[3].terms = {16'h0000, 16'hFFFE, 16'h0001, 16'h7FFF};
      tbl[4].terms = {16'h0001, 16'h0000, 16'h1234, 16'h8000};
      tbl[0].n = 4; tbl[0].exp = '{16'h0003, 16'hFFFF, 16'h0007, 16'hFFFB};
`ifdef TERM_SERIALIZER_SKIP_ZERO_EN
      tbl[1].n = 2; tbl[1].exp = '{16'h0005, 16'hFFFE, 16'h0000, 16'h0000};
      tbl[2].n = 1; tbl[2].exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      tbl[3].n = 3; tbl[3].exp = '{16'h7FFF, 16'h0001, 16'hFFFE, 16'h0000};
      tbl[4].n = 3; tbl[4].exp = '{16'h8000, 16'h1234, 16'h0001, 16'h0000};
`else
      tbl[1].n = 4; tbl[1].exp = '{16'h0000, 16'h0005, 16'h0000, 16'hFFFE};
      tbl[2].n = 4; tbl[2].exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      tbl[3].n = 4; tbl[3].exp = '{16'h7FFF, 16'h0001, 16'hFFFE, 16'h0000};
      tbl[4].n = 4; tbl[4].exp = '{16'h8000, 16'h1234, 16'h0000, 16'h0001};
`endif
      e3    = '{16'h0003, 16'hFFFF, 16'h0007, 16'hFFFB};
      e9    = '{16'h0009, 16'h0009, 16'h0009, 16'h0009};
      e1234 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      e10   = '{16'h000A, 16'h0014, 16'h001E, 16'h0028};

      rst_i = 1'b1; en_i = 1'b1; load_valid_i = 1'b0; terms_i = '0;
      #3;
      check("reset busy", 32'(busy_o), 32'd0);
      check("reset valid", 32'(valid_o), 32'd0);
      check("reset clear", 32'(clear_o), 32'd0);
      check("reset last", 32'(last_o), 32'd0);
      check("reset data", 32'($unsigned(data_o)), 32'd0);
      check("reset ready", 32'(load_ready_o), 32'd1);
      cyc(); cyc();
      rst_i = 1'b0;
      en_i  = 1'b0;
      #1;
      check("idle ready en low", 32'(load_ready_o), 32'd0);
      en_i = 1'b1;
      #1;

      for (int r = 0; r < 5; r++) begin
         apply_stimulus(tbl[r].terms);
         expect_stream($sformatf("row%0d", r), tbl[r].exp, tbl[r].n);
         if (r == 3) begin
            check("acc sum", 32'(acc), 32'd32766);
            check("acc ovf", 32'(acc_ovf), 32'd0);
         end
      end

      // load_valid_i held high across a whole transfer with a second vector waiting
      accept_cnt   = 0;
      terms_i      = {16'd40, 16'd30, 16'd20, 16'd10};
      load_valid_i = 1'b1;
      cyc();
      terms_i = {16'd4, 16'd3, 16'd2, 16'd1};
      #1;
      expect_stream("hold v1", e10, 4);
      cyc();
      load_valid_i = 1'b0;
      #1;
      expect_stream("hold v2", e1234, 4);
      check("hold accepts", 32'(accept_cnt), 32'd2);

      // enable stall after term 1
      apply_stimulus(tbl[0].terms);
      check("stall clear", 32'(clear_o), 32'd1);
      cyc();
      check("stall t0", 32'($unsigned(data_o)), 32'h0003);
      cyc();
      check("stall t1", 32'($unsigned(data_o)), 32'hFFFF);
      cyc();
      en_i = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         check($sformatf("stall%0d valid", s), 32'(valid_o), 32'd0);
         check($sformatf("stall%0d data", s), 32'($unsigned(data_o)), 32'd0);
         check($sformatf("stall%0d busy", s), 32'(busy_o), 32'd1);
         check($sformatf("stall%0d ready", s), 32'(load_ready_o), 32'd0);
         if (s < 2) cyc();
      end
      cyc();
      en_i = 1'b1;
      #1;
      check("resume t2 valid", 32'(valid_o), 32'd1);
      check("resume t2 data", 32'($unsigned(data_o)), 32'h0007);
      cyc();
      check("resume t3 data", 32'($unsigned(data_o)), 32'hFFFB);
      check("resume t3 last", 32'(last_o), 32'd1);
      cyc();
      check("resume end ready", 32'(load_ready_o), 32'd1);

      // asynchronous reset mid-stream after term 2
      apply_stimulus(tbl[0].terms);
      cyc(); cyc(); cyc();
      check("prerst t2", 32'($unsigned(data_o)), 32'h0007);
      #2;
      rst_i = 1'b1;
      #1;
      check("rst valid", 32'(valid_o), 32'd0);
      check("rst data", 32'($unsigned(data_o)), 32'd0);
      check("rst busy", 32'(busy_o), 32'd0);
      check("rst last", 32'(last_o), 32'd0);
      check("rst ready", 32'(load_ready_o), 32'd1);
      cyc();
      rst_i = 1'b0;
      #1;
      cyc();
      check("post rst valid", 32'(valid_o), 32'd0);
      check("post rst busy", 32'(busy_o), 32'd0);
      apply_stimulus({16'd9, 16'd9, 16'd9, 16'd9});
      expect_stream("after rst", e9, 4);

      // sanity: first table row again, ensures shadow not stale after reset
      apply_stimulus(tbl[0].terms);
      expect_stream("again", e3, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
